// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage PC sequencer: picks the PC register's next value and hold, and drives the IF/ID and ID/EX flushes.
// Optional stall performance counter enabled by defining PC_FETCH_CTRL_PERF_EN.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          FPU_TIMEOUT = 64
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] pc_q_in,
  input  logic        icache_hit_in,
  input  logic        icache_fill_done_in,
  input  logic        load_use_in,
  input  logic        fpu_start_in,
  input  logic        fpu_done_in,
  input  logic        bp_taken_in,
  input  logic [31:0] bp_target_in,
  input  logic        mispredict_in,
  input  logic [31:0] redirect_pc_in,
  output logic [31:0] pc_next_out,
  output logic        pc_remain_out,
  output logic        flush_if_id_out,
  output logic        flush_id_ex_out,
  output logic        fpu_timeout_err_out,
  output logic [31:0] stall_cycles_out
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    IMISS    = 2'd1,
    FPU_WAIT = 2'd2
  } state_t;

  localparam logic [9:0] TO_LAST = 10'(FPU_TIMEOUT - 1);

  generate
    if (FPU_TIMEOUT < 2 || FPU_TIMEOUT > 1023) begin : g_bad_timeout
      $error("pc_fetch_ctrl: FPU_TIMEOUT must be in 2..1023");
    end
  endgenerate

  // The PC register owns its reset value; it is carried here for documentation only.
  logic [31:0] reset_pc_unused;
  assign reset_pc_unused = RESET_PC;

  state_t      state_q, state_d;
  logic        pend_v_q, pend_v_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic [9:0]  to_cnt_q, to_cnt_d;
  logic        err_q, err_d;

  logic [31:0] redirect_pc_al;
  logic [31:0] bp_target_al;
  logic [31:0] seq_pc;
  logic        in_wait;
  logic        fpu_timeout_hit;
  logic        exit_wait;
  logic        apply_pend;
  logic [31:0] apply_pc;

  assign redirect_pc_al  = redirect_pc_in & 32'hFFFF_FFFC;
  assign bp_target_al    = bp_target_in & 32'hFFFF_FFFC;
  assign seq_pc          = pc_q_in + 32'd4;
  assign in_wait         = (state_q == IMISS) || (state_q == FPU_WAIT);
  assign fpu_timeout_hit = (state_q == FPU_WAIT) && (to_cnt_q == TO_LAST);
  assign exit_wait       = ((state_q == IMISS) && icache_fill_done_in) ||
                           ((state_q == FPU_WAIT) && (fpu_done_in || fpu_timeout_hit));
  // A redirect arriving on the exit cycle itself beats the one already pending.
  assign apply_pend      = exit_wait && (pend_v_q || mispredict_in);
  assign apply_pc        = mispredict_in ? redirect_pc_al : pend_pc_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= RUN;
      pend_v_q  <= 1'b0;
      pend_pc_q <= 32'h0;
      to_cnt_q  <= 10'h0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_v_q  <= pend_v_d;
      pend_pc_q <= pend_pc_d;
      to_cnt_q  <= to_cnt_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pend_v_d  = pend_v_q;
    pend_pc_d = pend_pc_q;
    to_cnt_d  = to_cnt_q;
    err_d     = err_q;
    case (state_q)
      RUN: begin
        if (mispredict_in) begin
          state_d = RUN;
        end else if (!icache_hit_in) begin
          state_d = IMISS;
        end else if (fpu_start_in) begin
          state_d  = FPU_WAIT;
          to_cnt_d = 10'h0;
        end
      end
      IMISS, FPU_WAIT: begin
        if (state_q == FPU_WAIT) begin
          to_cnt_d = to_cnt_q + 10'd1;
          if (fpu_timeout_hit && !fpu_done_in) begin
            err_d = 1'b1;
          end
        end
        if (mispredict_in) begin
          pend_v_d  = 1'b1;
          pend_pc_d = redirect_pc_al;
        end
        if (exit_wait) begin
          state_d  = RUN;
          pend_v_d = 1'b0;
        end
      end
      default: begin
        state_d  = RUN;
        pend_v_d = 1'b0;
      end
    endcase
  end

  // Outputs are combinational so the PC register reacts on the same edge.
  always_comb begin
    pc_next_out     = pc_q_in;
    pc_remain_out   = 1'b1;
    flush_if_id_out = 1'b0;
    flush_id_ex_out = 1'b0;
    if (!rst_in) begin
      case (state_q)
        RUN: begin
          if (mispredict_in) begin
            pc_next_out     = redirect_pc_al;
            pc_remain_out   = 1'b0;
            flush_if_id_out = 1'b1;
            flush_id_ex_out = 1'b1;
          end else if (!icache_hit_in) begin
            flush_if_id_out = 1'b1;
          end else if (fpu_start_in || load_use_in) begin
            flush_id_ex_out = 1'b1;
          end else if (bp_taken_in) begin
            pc_next_out   = bp_target_al;
            pc_remain_out = 1'b0;
          end else begin
            pc_next_out   = seq_pc;
            pc_remain_out = 1'b0;
          end
        end
        IMISS, FPU_WAIT: begin
          flush_if_id_out = (state_q == IMISS);
          flush_id_ex_out = (state_q == FPU_WAIT) || mispredict_in;
          if (apply_pend) begin
            pc_next_out   = apply_pc;
            pc_remain_out = 1'b0;
          end
        end
        default: begin
          pc_remain_out = 1'b1;
        end
      endcase
    end
  end

  assign fpu_timeout_err_out = err_q;

`ifdef PC_FETCH_CTRL_PERF_EN
  logic [31:0] stall_cnt_q;

  // Saturating count of held cycles outside reset.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      stall_cnt_q <= 32'h0;
    end else if (pc_remain_out && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cycles_out = stall_cnt_q;
`else
  assign stall_cycles_out = 32'h0;
`endif

endmodule

// File: doc/pc_fetch_ctrl.md
# pc_fetch_ctrl

Fetch-stage sequencer for the 32-bit PC register. It computes the PC register's next value and its hold (`PC_remain`) input every cycle. It arbitrates between four sources of PC change: sequential advance, branch-predictor target, EX-stage mispredict redirect and pipeline stalls (I-cache miss, multi-cycle FPU op, load-use). It also generates the IF/ID and ID/EX flush strobes.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value used when the PC register has been reset; documented only, not driven by this block.
- `FPU_TIMEOUT`, default 64: maximum FPU_WAIT cycles before forced exit, range 2..1023.
- `clk_in`  in  1  clock, rising edge.
- `rst_in`  in  1  asynchronous, active-high reset.
- `pc_q_in`  in  32  current PC register output.
- `icache_hit_in`  in  1  fetch at `pc_q_in` hit this cycle.
- `icache_fill_done_in`  in  1  one-cycle pulse, refill complete.
- `load_use_in`  in  1  decode load-use hazard.
- `fpu_start_in`  in  1  multi-cycle FPU op entered EX.
- `fpu_done_in`  in  1  FPU result valid.
- `bp_taken_in`  in  1  predictor says taken for `pc_q_in`.
- `bp_target_in`  in  32  predicted target.
- `mispredict_in`  in  1  EX resolved a mispredict.
- `redirect_pc_in`  in  32  correct PC from EX.
- `pc_next_out`  out  32  D input of the PC register.
- `pc_remain_out`  out  1  hold the PC register (1 = hold).
- `flush_if_id_out`  out  1  squash the IF/ID register.
- `flush_id_ex_out`  out  1  insert a bubble into ID/EX.
- `fpu_timeout_err_out`  out  1  sticky error flag.
- `stall_cycles_out`  out  32  performance counter (see Configuration).

## Operation
- FSM states: RUN=0, IMISS=1, FPU_WAIT=2. Registered state: FSM state, `pend_v`, `pend_pc[31:0]`, `to_cnt[9:0]`, error flag, performance counter.
- All target PCs have bits [1:0] forced to 0. Sequential advance is `pc_q_in + 4`, modulo 2^32.
- RUN priority, highest first:
  1. `mispredict_in`: `pc_next = redirect_pc_in`, remain=0, both flushes=1, stay RUN. Miss, FPU start and load-use are ignored this cycle.
  2. `!icache_hit_in`: remain=1, flush_if_id=1, go to IMISS.
  3. `fpu_start_in`: remain=1, flush_id_ex=1, go to FPU_WAIT, `to_cnt` cleared.
  4. `load_use_in`: remain=1, flush_id_ex=1, stay RUN.
  5. `bp_taken_in`: `pc_next = bp_target_in`, remain=0.
  6. Otherwise: `pc_next = pc_q_in + 4`, remain=0.
- IMISS:
  - remain=1 and flush_if_id=1 every cycle.
  - `mispredict_in` sets `pend_v` and loads `pend_pc`; flush_id_ex=1 that cycle. A later mispredict overwrites the pending PC.
  - On `icache_fill_done_in`: go to RUN. If `pend_v` (registered, or set this same cycle), `pc_next = pend_pc` (same-cycle redirect takes precedence), remain=0, and `pend_v` clears. Otherwise remain stays 1 and RUN re-evaluates the hit on the next cycle.
- FPU_WAIT:
  - remain=1 and flush_id_ex=1 every cycle; `to_cnt` increments.
  - Pending-redirect capture works the same as in IMISS.
  - Exit to RUN on `fpu_done_in`, or when `to_cnt == FPU_TIMEOUT-1`; the timeout exit also sets the error flag. On exit, the pending redirect is applied as in IMISS.
  - The error flag clears only on reset.
- `pc_next_out` equals `pc_q_in` whenever remain=1.

## Timing
- `pc_next_out`, `pc_remain_out` and both flush outputs are combinational from state and inputs, so the PC register updates on the same edge.
- State, pending and counter registers update on the rising edge of `clk_in`.
- While `rst_in` is high:
  - `pc_remain_out=1`, `pc_next_out=pc_q_in`, both flushes=0, error=0, `stall_cycles_out=0`.
  - State resets to RUN and `pend_v` to 0.
  - Release acts on the first rising edge after deassertion.
- Reset asserted mid-IMISS or mid-FPU_WAIT aborts immediately and discards the pending redirect.
- Load-use costs 1 cycle. A miss costs fill latency plus 1. The FPU wait lasts until `fpu_done_in` or at most `FPU_TIMEOUT` cycles.

## Configuration
- `PC_FETCH_CTRL_PERF_EN` defined: `stall_cycles_out` counts the cycles with `pc_remain_out=1` and `rst_in=0`, saturating at 32'hFFFF_FFFF.
- Undefined: `stall_cycles_out` is tied to 0, the counter logic is absent, and the port list is unchanged.

## Test plan
- Sequential and predicted fetch:
  - `pc_q_in=0xFFFF_FFFC`, hit, no events -> `pc_next_out=0x0`, remain=0.
  - `bp_taken_in=1`, target `0x103` -> `pc_next_out=0x100`.
- Miss with pending redirect:
  - Hit=0 at PC 0x40 -> IMISS, remain=1 for 5 cycles.
  - Mispredict to 0x200 in cycle 2 -> flush_id_ex pulse.
  - Fill pulse in cycle 5 -> `pc_next_out=0x200`, remain=0, RUN.
- Same-cycle priority: mispredict + miss + `fpu_start_in` + `load_use_in` in RUN -> `pc_next=redirect`, both flushes=1, state stays RUN.
- FPU timeout:
  - `FPU_TIMEOUT=4`, `fpu_start_in`, no done -> remain=1 for 5 cycles (start + 4 wait), RUN on 6th, `fpu_timeout_err_out=1` and sticky.
  - With `PC_FETCH_CTRL_PERF_EN`: `stall_cycles_out=5`.
- Load-use: a 1-cycle `load_use_in` -> exactly one cycle of remain=1 and flush_id_ex=1, then the PC advances by 4.
- Reset mid-FPU_WAIT with a pending redirect -> outputs go to reset values immediately, and the first post-reset cycle is RUN with no redirect applied.
